// File: rtl/reg_file_8x8.sv
// Eight-entry register file: one write port, two registered read ports.
// A write to an address being read in the same cycle is forwarded to that read,
// so a dependent instruction issued right behind a writeback sees the new value.
// HOLD freezes every piece of state, including the pending write.
module reg_file_8x8 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  input  logic              HOLD,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  output logic              VALID
);

  localparam int DEPTH = 1 << ADDR_W;

  // Registers are plain flops: the whole array must clear asynchronously.
  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DATA_W-1:0] r_out1;
  logic [DATA_W-1:0] r_out2;
  logic              r_valid;

  logic              w_we;
  logic [DEPTH-1:0]  w_wsel;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  // A stall overrides the write request.
  assign w_we = WRITE & ~HOLD;

  // One-hot write select, one decoder bit per register.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wsel
      assign w_wsel[gi] = w_we && (INADDRESS == ADDR_W'(gi));
    end
  endgenerate

  // Read data with same-cycle write forwarding; each port bypasses on its own.
  assign w_rd1 = (w_we && (OUT1ADDRESS == INADDRESS)) ? IN : r_regs[OUT1ADDRESS];
  assign w_rd2 = (w_we && (OUT2ADDRESS == INADDRESS)) ? IN : r_regs[OUT2ADDRESS];

  // Register array update; register 0 is an ordinary writable entry.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wsel[i]) begin
          r_regs[i] <= IN;
        end
      end
    end
  end

  // Registered read ports and valid flag; all hold while stalled.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_out1  <= '0;
      r_out2  <= '0;
      r_valid <= 1'b0;
    end else if (!HOLD) begin
      r_out1  <= w_rd1;
      r_out2  <= w_rd2;
      r_valid <= 1'b1;
    end
  end

  assign OUT1  = r_out1;
  assign OUT2  = r_out2;
  assign VALID = r_valid;

endmodule
